mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-ported 16-bit memory between the instruction-fetch requester (IF) and the load/store requester (D).
- Serialises their accesses through a req/ready/rvalid memory handshake.
- Data accesses have priority. A starvation guard ensures fetch progress.
- Sits between the fetch/PC stage and the Dmem stage of the pipelined CPU, in front of a unified memory.

Parameters:
- ADDR_W, 16, address width.
- DATA_W, 16, data width.
- STARVE_LIMIT, 4, consecutive D grants while IF is pending before IF is forced to win (1..15).

Ports:
- clk  in  1  clock, rising edge.
- nreset  in  1  asynchronous active-low reset.
- if_req  in  1  fetch request; held with if_addr until if_gnt.
- if_addr  in  ADDR_W  fetch address.
- if_gnt  out  1  one-cycle pulse: IF request accepted.
- if_valid  out  1  one-cycle pulse: if_rdata valid.
- if_rdata  out  DATA_W  fetched word.
- d_req  in  1  data request; held with d_we/d_addr/d_wdata until d_gnt.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  store data.
- d_gnt  out  1  one-cycle pulse: D request accepted.
- d_valid  out  1  one-cycle pulse: load data valid, or store complete.
- d_rdata  out  DATA_W  load data.
- mem_req  out  1  memory request, held until mem_ready.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_ready  in  1  memory accepted mem_req this cycle.
- mem_rvalid  in  1  read data valid.
- mem_rdata  in  DATA_W  read data.
- busy  out  1  high in any state except IDLE.
- perf_if_wait  out  16  IF wait-cycle counter (optional feature).
- perf_d_wait  out  16  D wait-cycle counter (optional feature).

Behaviour:
- Reset (nreset low, asynchronous):
  - State goes to IDLE.
  - All outputs are 0, including rdata registers.
  - Starvation counter is 0.
  - An in-flight access is abandoned; no valid pulse follows it.
- State IDLE:
  - If neither request is high, stay in IDLE.
  - Otherwise select a winner:
    - D wins if d_req is high, unless if_req is high and starve_cnt == STARVE_LIMIT.
    - Else IF wins.
  - On the selecting edge:
    - Register the winner's fields onto mem_*.
    - Set mem_req = 1 (mem_we = 0 for IF).
    - Pulse the winner's gnt for that cycle (combinational from IDLE plus selection).
    - Go to ISSUE.
  - Requesters may change or drop req after gnt.
- State ISSUE:
  - mem_req stays high and mem_* stay stable until mem_ready.
  - On mem_ready, mem_req drops on the next edge.
  - Write completes: d_valid pulses on the next cycle, then go to IDLE.
  - Read, mem_rvalid low: go to WAIT_RD.
  - Read, mem_rvalid also high in the same cycle: capture the data and go to RESP.
- State WAIT_RD:
  - On mem_rvalid, capture mem_rdata into the owner's rdata register and go to RESP.
  - Wait is unbounded.
- State RESP:
  - The owner's valid pulses for one cycle; go to IDLE.
  - rdata holds its value until the next capture.
- Latency with zero-wait memory: gnt in cycle 0, mem_req in cycle 1, valid in cycle 3.
- Back-to-back: a new selection happens only from IDLE. Max throughput is one access per 3 cycles.
- Starvation counter (saturating at STARVE_LIMIT):
  - Increments on each D grant while if_req is high.
  - Clears on IF grant or whenever if_req is low in IDLE.
- mem_rvalid outside ISSUE/WAIT_RD is ignored.
- mem_ready while mem_req is low is ignored.

Optional Feature:
- MEM_ARB_PERF_CNT_EN defined:
  - perf_if_wait counts cycles with if_req high and if_gnt low.
  - perf_d_wait counts cycles with d_req high and d_gnt low.
  - Both counters saturate at 0xFFFF and clear on reset.
- Not defined: both ports are tied to 0 and no counter flops exist.

Decomposition:
- Package mem_arb_pkg:
  - State encoding: IDLE = 2'd0, ISSUE = 2'd1, WAIT_RD = 2'd2, RESP = 2'd3.
  - Owner IDs: OWN_IF = 1'b0, OWN_D = 1'b1.
  - Default widths.
- Sub-module arb_starve_sel:
  - Holds the starvation counter.
  - Contains the combinational winner select.
  - Inputs: if_req, d_req, sel_en, gnt_owner. Output: winner.

Test Plan:
- Single fetch, zero-wait memory: if_req = 1, if_addr = 0x0010; memory returns ready in the same cycle and rvalid one cycle later with 0xE3A0 -> if_gnt in cycle 0, mem_addr = 0x0010 with mem_we = 0, if_valid with if_rdata = 0xE3A0 in cycle 3, busy low afterwards.
- Simultaneous requests: if_req and d_req both high, d_we = 1, d_addr = 0x0040, d_wdata = 0x1234 -> d_gnt first, mem_we = 1 with data 0x1234, d_valid after ready; IF granted on the next IDLE.
- Starvation: d_req held high continuously with if_req high, STARVE_LIMIT = 4 -> grants are D,D,D,D,IF,D...; counter returns to 0 after the IF grant.
- Memory wait states: mem_ready delayed 3 cycles, then mem_rvalid 2 cycles later -> mem_req held and mem_addr stable throughout, exactly one valid pulse, no second grant while busy.
- Reset mid-read: nreset asserted in WAIT_RD -> mem_req and busy go to 0 immediately; a later mem_rvalid produces no valid pulse; the next request is served normally.
- With MEM_ARB_PERF_CNT_EN defined: IF blocked for 5 cycles -> perf_if_wait = 5. Without the macro -> perf_if_wait = 0.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// mem_arb_pkg
// Shared definitions for the memory port arbiter slice: FSM state
// encoding, owner IDs, default widths and a small saturating-increment
// helper used by the optional wait-cycle counters.
package mem_arb_pkg;

  localparam int ADDR_W_DEF       = 16;
  localparam int DATA_W_DEF       = 16;
  localparam int STARVE_LIMIT_DEF = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT_RD = 2'd2,
    RESP    = 2'd3
  } arb_state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_e;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if
// Bundles the three handshakes around the arbiter:
//   if_*  : instruction-fetch requester (req/addr in, gnt/valid/rdata out)
//   d_*   : load/store requester (req/we/addr/wdata in, gnt/valid/rdata out)
//   mem_* : unified memory (req/we/addr/wdata out, ready/rvalid/rdata in)
// Modports:
//   slave  : the arbiter's view (serves requesters, drives the memory)
//   master : the environment's view (requesters plus memory)
interface mem_port_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_valid;
  logic [DATA_W-1:0] if_rdata;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt;
  logic              d_valid;
  logic [DATA_W-1:0] d_rdata;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ready;
  logic              mem_rvalid;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  if_req, if_addr,
    output if_gnt, if_valid, if_rdata,
    input  d_req, d_we, d_addr, d_wdata,
    output d_gnt, d_valid, d_rdata,
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ready, mem_rvalid, mem_rdata
  );

  modport master (
    output if_req, if_addr,
    input  if_gnt, if_valid, if_rdata,
    output d_req, d_we, d_addr, d_wdata,
    input  d_gnt, d_valid, d_rdata,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ready, mem_rvalid, mem_rdata
  );

endinterface

// File: rtl/mem_port_arbiter_starve_sel.sv
// arb_starve_sel
// Winner select for the arbiter plus the starvation counter that lets a
// pending fetch break through a continuous stream of data accesses.
// Ports:
//   clk, nreset : clock, asynchronous active-low reset
//   if_req      : fetch request pending
//   d_req       : data request pending
//   sel_en      : arbiter is in IDLE and may select this cycle
//   gnt_owner   : owner that receives the grant when a request is present
//   winner      : combinational winner for the current cycle
module arb_starve_sel
  import mem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic   clk,
  input  logic   nreset,
  input  logic   if_req,
  input  logic   d_req,
  input  logic   sel_en,
  input  owner_e gnt_owner,
  output owner_e winner
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0] starve_cnt_q, starve_cnt_d;

  // Data wins by default; a fetch that has watched LIMIT data grants go
  // by takes the next slot.
  always_comb begin
    winner = OWN_IF;
    if (d_req && !(if_req && (starve_cnt_q == LIMIT))) begin
      winner = OWN_D;
    end
  end

  // While IDLE: no pending fetch means nothing to protect, so clear.
  // A pending fetch is always granted to someone, so if_req high in
  // IDLE means a grant happens this cycle.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (sel_en) begin
      if (!if_req || (gnt_owner == OWN_IF)) begin
        starve_cnt_d = 4'd0;
      end else if (starve_cnt_q < LIMIT) begin
        starve_cnt_d = starve_cnt_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      starve_cnt_q <= 4'd0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-ported memory between the fetch requester (IF) and the
// load/store requester (D). Accesses are serialised through a
// req/ready/rvalid handshake; D has priority, with a starvation guard that
// forces an IF grant after STARVE_LIMIT consecutive D grants.
// Ports:
//   clk, nreset  : clock, asynchronous active-low reset
//   bus (slave)  : if_*, d_* requester handshakes and mem_* memory port
//   busy         : high whenever the FSM is not IDLE
//   perf_if_wait : cycles IF waited (if_req & !if_gnt), saturating
//   perf_d_wait  : cycles D waited (d_req & !d_gnt), saturating
// Build option: define MEM_ARB_PERF_CNT_EN to implement the perf counters;
// otherwise both perf outputs are tied to 0.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic                clk,
  input  logic                nreset,
  mem_port_arbiter_if.slave   bus,
  output logic                busy,
  output logic [15:0]         perf_if_wait,
  output logic [15:0]         perf_d_wait
);

  arb_state_e        state_q, state_d;
  owner_e            owner_q, owner_d;
  owner_e            winner;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              sel_en;
  logic              grant;

  assign sel_en = (state_q == IDLE);
  assign grant  = sel_en && (bus.if_req || bus.d_req);

  arb_starve_sel #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_starve_sel (
    .clk      (clk),
    .nreset   (nreset),
    .if_req   (bus.if_req),
    .d_req    (bus.d_req),
    .sel_en   (sel_en),
    .gnt_owner(winner),
    .winner   (winner)
  );

  // Grants are combinational so the requester sees acceptance in the same
  // cycle it is selected; valids come straight from the RESP state.
  assign bus.if_gnt    = grant && (winner == OWN_IF);
  assign bus.d_gnt     = grant && (winner == OWN_D);
  assign bus.if_valid  = (state_q == RESP) && (owner_q == OWN_IF);
  assign bus.d_valid   = (state_q == RESP) && (owner_q == OWN_D);
  assign bus.if_rdata  = if_rdata_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign busy          = (state_q != IDLE);

  // Next-state logic. mem_* is loaded only at selection so it stays stable
  // for the whole ISSUE phase; read data is steered to the owner's register.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;

    case (state_q)
      IDLE: begin
        if (grant) begin
          owner_d   = winner;
          mem_req_d = 1'b1;
          state_d   = ISSUE;
          if (winner == OWN_D) begin
            mem_we_d    = bus.d_we;
            mem_addr_d  = bus.d_addr;
            mem_wdata_d = bus.d_wdata;
          end else begin
            mem_we_d    = 1'b0;
            mem_addr_d  = bus.if_addr;
            mem_wdata_d = '0;
          end
        end
      end

      ISSUE: begin
        if (bus.mem_ready) begin
          mem_req_d = 1'b0;
          if (mem_we_q) begin
            state_d = RESP;
          end else if (bus.mem_rvalid) begin
            state_d = RESP;
            if (owner_q == OWN_IF) begin
              if_rdata_d = bus.mem_rdata;
            end else begin
              d_rdata_d = bus.mem_rdata;
            end
          end else begin
            state_d = WAIT_RD;
          end
        end
      end

      WAIT_RD: begin
        if (bus.mem_rvalid) begin
          state_d = RESP;
          if (owner_q == OWN_IF) begin
            if_rdata_d = bus.mem_rdata;
          end else begin
            d_rdata_d = bus.mem_rdata;
          end
        end
      end

      RESP: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Reset abandons any in-flight access: returning to IDLE means a late
  // rvalid has nothing to complete.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q     <= IDLE;
      owner_q     <= OWN_IF;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

`ifdef MEM_ARB_PERF_CNT_EN
  logic [15:0] perf_if_wait_q;
  logic [15:0] perf_d_wait_q;

  // Wait-cycle counters: a cycle counts when a request is up but not granted.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      perf_if_wait_q <= 16'd0;
      perf_d_wait_q  <= 16'd0;
    end else begin
      if (bus.if_req && !bus.if_gnt) begin
        perf_if_wait_q <= sat_inc16(perf_if_wait_q);
      end
      if (bus.d_req && !bus.d_gnt) begin
        perf_d_wait_q <= sat_inc16(perf_d_wait_q);
      end
    end
  end

  assign perf_if_wait = perf_if_wait_q;
  assign perf_d_wait  = perf_d_wait_q;
`else
  assign perf_if_wait = 16'd0;
  assign perf_d_wait  = 16'd0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
// Directed bench for mem_port_arbiter. Inputs change on the falling edge and
// outputs are checked 1 time unit later; registered outputs are then stable
// and combinational grants reflect the freshly driven requests.
// Expected perf counts follow MEM_ARB_PERF_CNT_EN (0 when undefined).
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        nreset;
  logic        busy;
  logic [15:0] perf_if_wait;
  logic [15:0] perf_d_wait;
  logic [15:0] expPerf;
  logic        expD;
  int          vectors = 0;
  int          miscompares = 0;

  mem_port_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus ();

  mem_port_arbiter #(
    .ADDR_W      (16),
    .DATA_W      (16),
    .STARVE_LIMIT(4)
  ) dut (
    .clk         (clk),
    .nreset      (nreset),
    .bus         (bus),
    .busy        (busy),
    .perf_if_wait(perf_if_wait),
    .perf_d_wait (perf_d_wait)
  );

  always #5 clk = ~clk;

  // Advance to the next falling edge, drive the handshake controls, settle.
  task automatic applyStimulus(input logic ifReq, input logic dReq,
                               input logic memReady, input logic memRvalid);
    @(negedge clk);
    bus.if_req     = ifReq;
    bus.d_req      = dReq;
    bus.mem_ready  = memReady;
    bus.mem_rvalid = memRvalid;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic checkFlag(input string tag, input logic observed,
                           input logic expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %b expected %b", tag, observed, expected);
    end
  endtask

  // Guards against a hang; the directed sequence needs only a few hundred cycles.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed no finish expected finish by t=100000");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
`ifdef MEM_ARB_PERF_CNT_EN
    expPerf = 16'd5;
`else
    expPerf = 16'd0;
`endif
    nreset         = 1'b0;
    bus.if_req     = 1'b0;
    bus.if_addr    = 16'h0000;
    bus.d_req      = 1'b0;
    bus.d_we       = 1'b0;
    bus.d_addr     = 16'h0000;
    bus.d_wdata    = 16'h0000;
    bus.mem_ready  = 1'b0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = 16'h0000;

    // Reset state
    @(negedge clk); #1;
    checkFlag("rst_busy", busy, 1'b0);
    checkFlag("rst_mem_req", bus.mem_req, 1'b0);
    checkFlag("rst_if_valid", bus.if_valid, 1'b0);
    checkFlag("rst_d_valid", bus.d_valid, 1'b0);
    checkOutput("rst_if_rdata", bus.if_rdata, 16'h0000);
    checkOutput("rst_mem_addr", bus.mem_addr, 16'h0000);
    checkOutput("rst_perf_if", perf_if_wait, 16'h0000);
    nreset = 1'b1;

    // Single fetch, zero-wait memory
    bus.if_addr = 16'h0010;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkFlag("t1_if_gnt", bus.if_gnt, 1'b1);
    checkFlag("t1_d_gnt", bus.d_gnt, 1'b0);
    checkFlag("t1_busy_c0", busy, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    checkFlag("t1_mem_req", bus.mem_req, 1'b1);
    checkOutput("t1_mem_addr", bus.mem_addr, 16'h0010);
    checkFlag("t1_mem_we", bus.mem_we, 1'b0);
    checkFlag("t1_busy_c1", busy, 1'b1);
    bus.mem_rdata = 16'hE3A0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    checkFlag("t1_mem_req_drop", bus.mem_req, 1'b0);
    checkFlag("t1_if_valid_c2", bus.if_valid, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkFlag("t1_if_valid_c3", bus.if_valid, 1'b1);
    checkOutput("t1_if_rdata", bus.if_rdata, 16'hE3A0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkFlag("t1_if_valid_c4", bus.if_valid, 1'b0);
    checkFlag("t1_busy_c4", busy, 1'b0);

    // Simultaneous requests: store first, fetch on the next IDLE
    bus.if_addr = 16'h0020;
    bus.d_we    = 1'b1;
    bus.d_addr  = 16'h0040;
    bus.d_wdata = 16'h1234;
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    checkFlag("t2_d_gnt", bus.d_gnt, 1'b1);
    checkFlag("t2_if_gnt_c0", bus.if_gnt, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    checkFlag("t2_mem_req", bus.mem_req, 1'b1);
    checkFlag("t2_mem_we", bus.mem_we, 1'b1);
    checkOutput("t2_mem_wdata", bus.mem_wdata, 16'h1234);
    checkOutput("t2_mem_addr", bus.mem_addr, 16'h0040);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkFlag("t2_d_valid", bus.d_valid, 1'b1);
    checkFlag("t2_if_gnt_resp", bus.if_gnt, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkFlag("t2_if_gnt", bus.if_gnt, 1'b1);
    checkFlag("t2_d_valid_off", bus.d_valid, 1'b0);
    bus.mem_rdata = 16'hBEEF;
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
    checkOutput("t2_if_addr", bus.mem_addr, 16'h0020);
    checkFlag("t2_if_we", bus.mem_we, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkFlag("t2_if_valid", bus.if_valid, 1'b1);
    checkOutput("t2_if_rdata", bus.if_rdata, 16'hBEEF);

    // Starvation guard: both requests held, grants D,D,D,D,IF repeating
    bus.d_we      = 1'b1;
    bus.d_addr    = 16'h0080;
    bus.d_wdata   = 16'h5555;
    bus.if_addr   = 16'h0100;
    bus.mem_rdata = 16'h7777;
    for (int g = 0; g < 10; g++) begin
      expD = (g != 4) && (g != 9);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
      checkFlag($sformatf("t3_d_gnt_%0d", g), bus.d_gnt, expD);
      checkFlag($sformatf("t3_if_gnt_%0d", g), bus.if_gnt, !expD);
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
      checkFlag($sformatf("t3_d_valid_%0d", g), bus.d_valid, expD);
      checkFlag($sformatf("t3_if_valid_%0d", g), bus.if_valid, !expD);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkFlag("t3_busy_end", busy, 1'b0);

    // Memory wait states on a load, with a fetch arriving while busy
    bus.d_we      = 1'b0;
    bus.d_addr    = 16'h0155;
    bus.if_addr   = 16'h0300;
    bus.mem_rdata = 16'h5A5A;
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkFlag("t4_d_gnt", bus.d_gnt, 1'b1);
    for (int w = 0; w < 3; w++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      checkFlag($sformatf("t4_mem_req_w%0d", w), bus.mem_req, 1'b1);
      checkOutput($sformatf("t4_mem_addr_w%0d", w), bus.mem_addr, 16'h0155);
      checkFlag($sformatf("t4_if_gnt_w%0d", w), bus.if_gnt, 1'b0);
    end
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    checkFlag("t4_mem_req_rdy", bus.mem_req, 1'b1);
    checkOutput("t4_mem_addr_rdy", bus.mem_addr, 16'h0155);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkFlag("t4_mem_req_wait", bus.mem_req, 1'b0);
    checkFlag("t4_d_valid_wait", bus.d_valid, 1'b0);
    checkFlag("t4_if_gnt_wait", bus.if_gnt, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    checkFlag("t4_d_valid_rv", bus.d_valid, 1'b0);
    checkFlag("t4_if_gnt_rv", bus.if_gnt, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkFlag("t4_d_valid", bus.d_valid, 1'b1);
    checkOutput("t4_d_rdata", bus.d_rdata, 16'h5A5A);
    checkFlag("t4_if_valid", bus.if_valid, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkFlag("t4_d_valid_once", bus.d_valid, 1'b0);
    checkFlag("t4_if_gnt", bus.if_gnt, 1'b1);
    bus.mem_rdata = 16'h0F0F;
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
    checkOutput("t4_if_mem_addr", bus.mem_addr, 16'h0300);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkFlag("t4_if_valid_end", bus.if_valid, 1'b1);
    checkOutput("t4_if_rdata", bus.if_rdata, 16'h0F0F);
    checkOutput("t4_d_rdata_hold", bus.d_rdata, 16'h5A5A);

    // Reset while waiting for read data
    bus.if_addr = 16'h0400;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkFlag("t5_if_gnt", bus.if_gnt, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkFlag("t5_busy_wait", busy, 1'b1);
    nreset = 1'b0;
    #1;
    checkFlag("t5_mem_req_rst", bus.mem_req, 1'b0);
    checkFlag("t5_busy_rst", busy, 1'b0);
    checkOutput("t5_if_rdata_rst", bus.if_rdata, 16'h0000);
    @(negedge clk);
    nreset = 1'b1;
    bus.mem_rdata = 16'hDEAD;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    checkFlag("t5_if_valid_late", bus.if_valid, 1'b0);
    checkFlag("t5_busy_late", busy, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkFlag("t5_if_valid_after", bus.if_valid, 1'b0);
    checkOutput("t5_if_rdata_after", bus.if_rdata, 16'h0000);
    bus.d_we    = 1'b1;
    bus.d_addr  = 16'h0050;
    bus.d_wdata = 16'hCAFE;
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkFlag("t5_d_gnt", bus.d_gnt, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("t5_mem_wdata", bus.mem_wdata, 16'hCAFE);
    checkOutput("t5_mem_addr", bus.mem_addr, 16'h0050);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkFlag("t5_d_valid", bus.d_valid, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkFlag("t5_busy_end", busy, 1'b0);

    // Wait counters: fetch blocked for 5 cycles behind a slow store
    nreset = 1'b0;
    @(negedge clk);
    nreset = 1'b1;
    bus.d_we    = 1'b1;
    bus.d_addr  = 16'h0060;
    bus.d_wdata = 16'h0001;
    bus.if_addr = 16'h0500;
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    checkFlag("t6_d_gnt", bus.d_gnt, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkFlag("t6_d_valid", bus.d_valid, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkFlag("t6_if_gnt", bus.if_gnt, 1'b1);
    checkOutput("t6_perf_if_wait", perf_if_wait, expPerf);
    checkOutput("t6_perf_d_wait", perf_d_wait, 16'h0000);
    bus.mem_rdata = 16'h1111;
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkFlag("t6_if_valid", bus.if_valid, 1'b1);
    checkOutput("t6_perf_if_hold", perf_if_wait, expPerf);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
